// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 key matrix and sends one debounced eBCD strobe per keystroke.
module keypad_encoder #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 20000,
    parameter int STROBE_LEN = 4
) (
    input  logic       sw_clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] eBCD
);
    localparam int CMAX = (SCAN_DIV > DEBOUNCE)
                        ? ((SCAN_DIV > STROBE_LEN) ? SCAN_DIV : STROBE_LEN)
                        : ((DEBOUNCE > STROBE_LEN) ? DEBOUNCE : STROBE_LEN);
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'ha,
        4'h4, 4'h5, 4'h6, 4'hb,
        4'h7, 4'h8, 4'h9, 4'hc,
        4'hd, 4'h0, 4'he, 4'hf
    };
    typedef enum logic [2:0] {SCAN, DEB, SETUP, STROBE, HOLD} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    row_m, row_s, pat, low, rot;
    logic [1:0]    ridx, row_idx, col_idx;
    logic          one_low;
    // A multi-key or ghost pattern has more than one low row and is ignored
    assign low     = ~row_s;
    assign one_low = (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);
    assign row_idx = {low[3] | low[2], low[3] | low[1]};
    assign col_idx = {~col[3] | ~col[2], ~col[3] | ~col[1]};
    assign rot     = {col[2:0], col[3]};
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
            state <= SCAN;
            cnt   <= '0;
            col   <= 4'b1110;
            eBCD  <= 5'b0_0000;
            pat   <= 4'hF;
            ridx  <= 2'd0;
        end else begin
            row_m <= row;
            row_s <= row_m;
            case (state)
                SCAN:
                    if (cnt == CW'(SCAN_DIV - 1)) begin
                        cnt <= '0;
                        if (one_low) begin
                            state <= DEB;
                            pat   <= row_s;
                            ridx  <= row_idx;
                        end else
                            col <= rot;
                    end else
                        cnt <= cnt + CW'(1);
                DEB:
                    if (row_s != pat) begin
                        state <= SCAN;
                        cnt   <= '0;
                    end else if (cnt == CW'(DEBOUNCE - 1)) begin
                        state <= SETUP;
                        cnt   <= '0;
                    end else
                        cnt <= cnt + CW'(1);
                SETUP: begin
                    eBCD[3:0] <= KEYMAP[{ridx, col_idx}];
                    state     <= STROBE;
                end
                // Code was loaded a cycle earlier, so the strobe rises on settled data
                STROBE:
                    if (cnt == CW'(STROBE_LEN)) begin
                        eBCD[4] <= 1'b0;
                        state   <= HOLD;
                        cnt     <= '0;
                    end else begin
                        eBCD[4] <= 1'b1;
                        cnt     <= cnt + CW'(1);
                    end
                HOLD:
                    if (row_s != 4'hF)
                        cnt <= '0;
                    else if (cnt == CW'(DEBOUNCE - 1)) begin
                        state <= SCAN;
                        cnt   <= '0;
                        col   <= rot;
                    end else
                        cnt <= cnt + CW'(1);
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed keypad scenarios against a timestamp-based reference model.
module tb_keypad_encoder;
    localparam int SD = 4, DB = 8, SL = 4;
    localparam int MS_SCAN = 0, MS_DEB = 1, MS_FIRE = 2, MS_HOLD = 3;
    logic        sw_clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row, col;
    logic [4:0]  eBCD;
    logic [15:0] pressed = 16'h0;
    int n_cmp = 0, n_bad = 0;
    int strobe_cnt = 0, stb_len = 0, in_stb = 0;
    logic [3:0] last_code, last_pre, prev_code;
    logic [4:0] last_word;
    int m_ci, m_mode, m_slot, m_run, m_rel, m_n, m_r, t_code, t_rise, t_fall;
    logic [3:0] m_pat, m_rs1, m_rs2, m_code, m_row;
    logic       m_stb;

    keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE(DB), .STROBE_LEN(SL)) dut (
        .sw_clk(sw_clk), .rst(rst), .row(row), .col(col), .eBCD(eBCD)
    );

    always #5 sw_clk = ~sw_clk;

    // Physical matrix: a pressed key pulls its row low only while its column is driven low
    function automatic logic [3:0] matrix(input logic [3:0] c, input logic [15:0] p);
        logic [3:0] r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (p[i*4+j] && !c[j]) r[i] = 1'b0;
        return r;
    endfunction

    assign row = matrix(col, pressed);

    function automatic logic [3:0] colv(input int i);
        logic [3:0] v = 4'b0001 << i;
        return ~v;
    endfunction

    function automatic logic [3:0] keycode(input int r, input int c);
        if (r == 3) return (c == 0) ? 4'hd : (c == 1) ? 4'h0 : (c == 2) ? 4'he : 4'hf;
        if (c == 3) return 4'(10 + r);
        return 4'(3 * r + c + 1);
    endfunction

    function automatic int low_row(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        return 0;
    endfunction

    function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: schedules code/strobe edges as absolute edge numbers after acceptance
    initial forever begin
        @(posedge sw_clk or negedge rst);
        if (!rst) begin
            m_ci = 0; m_mode = MS_SCAN; m_slot = 0; m_run = 0; m_rel = 0; m_n = 0; m_r = 0;
            t_code = -1; t_rise = -1; t_fall = -1;
            m_pat = 4'hF; m_rs1 = 4'hF; m_rs2 = 4'hF; m_code = 4'h0; m_stb = 1'b0;
        end else begin
            m_row = matrix(colv(m_ci), pressed);
            m_n++;
            if (m_mode == MS_SCAN) begin
                m_slot++;
                if (m_slot == SD) begin
                    m_slot = 0;
                    if ($countones(~m_rs2) == 1) begin
                        m_mode = MS_DEB; m_run = 0; m_pat = m_rs2; m_r = low_row(m_rs2);
                    end else
                        m_ci = (m_ci + 1) % 4;
                end
            end else if (m_mode == MS_DEB) begin
                if (m_rs2 != m_pat) begin
                    m_mode = MS_SCAN; m_slot = 0;
                end else begin
                    m_run++;
                    if (m_run == DB) begin
                        m_mode = MS_FIRE; t_code = m_n + 1; t_rise = m_n + 2; t_fall = m_n + 2 + SL;
                    end
                end
            end else if (m_mode == MS_FIRE) begin
                if (m_n == t_code) m_code = keycode(m_r, m_ci);
                if (m_n == t_rise) m_stb = 1'b1;
                if (m_n == t_fall) begin
                    m_stb = 1'b0; m_mode = MS_HOLD; m_rel = 0;
                end
            end else begin
                m_rel = (m_rs2 == 4'hF) ? m_rel + 1 : 0;
                if (m_rel == DB) begin
                    m_mode = MS_SCAN; m_slot = 0; m_ci = (m_ci + 1) % 4;
                end
            end
            m_rs2 = m_rs1;
            m_rs1 = m_row;
        end
    end

    // Per-cycle compare plus strobe monitor
    initial forever begin
        @(negedge sw_clk);
        chk("col", col, colv(m_ci));
        chk("ebcd", eBCD, {m_stb, m_code});
        if (!rst)
            in_stb = 0;
        else if (eBCD[4] && in_stb == 0) begin
            in_stb = 1; stb_len = 1; strobe_cnt++;
            last_code = eBCD[3:0]; last_word = eBCD; last_pre = prev_code;
            chk("setup", prev_code, eBCD[3:0]);
        end else if (eBCD[4])
            stb_len++;
        else if (in_stb != 0) begin
            in_stb = 0;
            chk("strobe_len", stb_len, SL);
        end
        prev_code = eBCD[3:0];
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sw_clk);
        #2;
    endtask

    task automatic wait_col(input logic [3:0] c);
        int t = 0;
        while (col !== c && t < 60) begin tick(1); t++; end
        chk("wait_col", col, c);
    endtask

    task automatic wait_stb(input int base);
        int t = 0;
        while (strobe_cnt == base && t < 200) begin tick(1); t++; end
    endtask

    initial begin
        int base;
        #1 rst = 1'b0;
        tick(3);
        chk("reset_col", col, 4'b1110);
        chk("reset_ebcd", eBCD, 8'h00);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 3)  chk("rot0", col, 4'b1110);
            if (k == 4)  chk("rot1", col, 4'b1101);
            if (k == 8)  chk("rot2", col, 4'b1011);
            if (k == 12) chk("rot3", col, 4'b0111);
            if (k == 16) chk("rot4", col, 4'b1110);
        end
        // Clean press of 9
        wait_col(4'b1011);
        base = strobe_cnt;
        pressed[2*4+2] = 1'b1;
        tick(40);
        chk("clean_count", 8'(strobe_cnt - base), 8'd1);
        chk("clean_word", last_word, 8'h19);
        chk("clean_setup", last_pre, 8'h9);
        chk("clean_after", eBCD, 8'h09);
        pressed = 16'h0;
        tick(9);
        chk("clean_hold_col", col, 4'b1011);
        tick(1);
        chk("clean_resume_col", col, 4'b0111);
        // Bouncing key 1
        wait_col(4'b1110);
        base = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            pressed[0] = (i % 2 == 0);
            tick(3);
        end
        chk("bounce_none", 8'(strobe_cnt - base), 8'd0);
        pressed[0] = 1'b1;
        wait_stb(base);
        tick(6);
        chk("bounce_count", 8'(strobe_cnt - base), 8'd1);
        chk("bounce_code", last_code, 8'h1);
        pressed = 16'h0;
        tick(20);
        // Two keys in one column, then one released
        wait_col(4'b1101);
        base = strobe_cnt;
        pressed[1*4+1] = 1'b1;
        pressed[3*4+1] = 1'b1;
        tick(30);
        chk("multi_none", 8'(strobe_cnt - base), 8'd0);
        pressed[3*4+1] = 1'b0;
        wait_stb(base);
        tick(6);
        chk("multi_count", 8'(strobe_cnt - base), 8'd1);
        chk("multi_code", last_code, 8'h5);
        pressed = 16'h0;
        tick(20);
        // '=' held while '*' is added
        base = strobe_cnt;
        pressed[3*4+3] = 1'b1;
        wait_stb(base);
        tick(6);
        chk("held_code", last_code, 8'hf);
        pressed[1*4+3] = 1'b1;
        tick(30);
        chk("held_count", 8'(strobe_cnt - base), 8'd1);
        pressed = 16'h0;
        tick(20);
        base = strobe_cnt;
        pressed[0*4+1] = 1'b1;
        wait_stb(base);
        tick(6);
        chk("next_count", 8'(strobe_cnt - base), 8'd1);
        chk("next_code", last_code, 8'h2);
        pressed = 16'h0;
        tick(20);
        // Reset on the second strobe cycle
        base = strobe_cnt;
        pressed[2*4+1] = 1'b1;
        wait_stb(base);
        chk("pre_rst_strobe", eBCD, 8'h18);
        rst = 1'b0;
        #1;
        chk("rst_ebcd", eBCD, 8'h00);
        chk("rst_col", col, 4'b1110);
        pressed = 16'h0;
        tick(3);
        rst = 1'b1;
        base = strobe_cnt;
        pressed[3*4+1] = 1'b1;
        wait_stb(base);
        tick(6);
        chk("resume_count", 8'(strobe_cnt - base), 8'd1);
        chk("resume_code", last_code, 8'h0);
        pressed = 16'h0;
        tick(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
